// File: rtl/semaforo_pkg.sv
// Shared phase encoding and default phase timings for the traffic-light
// controller and its phase-duration timer.
package semaforo_pkg;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        GREEN   = 3'd1,
        YELLOW  = 3'd2,
        RED     = 3'd3,
        ILLEGAL = 3'd4
    } phase_t;

    localparam int DEF_PRESCALE     = 50_000_000;
    localparam int DEF_GREEN_TICKS  = 10;
    localparam int DEF_YELLOW_TICKS = 3;
    localparam int DEF_RED_TICKS    = 8;

    // Exactly one light lit selects a phase; anything else is a wiring/controller fault.
    function automatic phase_t decode_phase(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return GREEN;
            3'b010:  return YELLOW;
            3'b001:  return RED;
            default: return ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing one tick every PRESCALE cycles;
// clear restarts the count and suppresses a tick in the same cycle.
module tick_prescaler #(
    parameter int PRESCALE = 50_000_000,
    parameter int PW       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    assign tick    = at_last && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || at_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/semaforo_timer.sv
// Phase-duration timer: watches the controller's lights and raises the
// matching elapsed flag once the current phase has lasted its tick budget.
module semaforo_timer
    import semaforo_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int RED_TICKS    = DEF_RED_TICKS,
    parameter int TW           = 8,
    parameter int PW           = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          green,
    input  logic          yellow,
    input  logic          red,
    output logic          counter_green,
    output logic          counter_yellow,
    output logic          counter_red,
    output logic [TW-1:0] remaining,
    output logic          fault
);

    phase_t        phase_q;
    phase_t        phase_d;
    logic          phase_change;
    logic          tick;
    logic          done;
    logic [TW-1:0] elapsed;
    logic [TW-1:0] elapsed_nxt;
    logic [TW-1:0] cur_dur;

    // NONE and ILLEGAL have zero duration, which also blocks counting in them.
    function automatic logic [TW-1:0] dur_of(input phase_t p);
        case (p)
            GREEN:   return TW'(GREEN_TICKS);
            YELLOW:  return TW'(YELLOW_TICKS);
            RED:     return TW'(RED_TICKS);
            default: return '0;
        endcase
    endfunction

    assign phase_d      = decode_phase(green, yellow, red);
    assign phase_change = (phase_d != phase_q);
    assign done         = counter_green | counter_yellow | counter_red;
    assign elapsed_nxt  = elapsed + TW'(1);
    assign cur_dur      = dur_of(phase_q);

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (phase_change),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q        <= NONE;
            elapsed        <= '0;
            remaining      <= '0;
            counter_green  <= 1'b0;
            counter_yellow <= 1'b0;
            counter_red    <= 1'b0;
            fault          <= 1'b0;
        end else begin
            phase_q <= phase_d;
            fault   <= (phase_d == ILLEGAL);
            if (phase_change) begin
                elapsed        <= '0;
                remaining      <= dur_of(phase_d);
                counter_green  <= 1'b0;
                counter_yellow <= 1'b0;
                counter_red    <= 1'b0;
            end else if (tick && !done && (cur_dur != '0)) begin
                // Once done is set, elapsed/remaining freeze at DUR/0 until the next phase.
                elapsed   <= elapsed_nxt;
                remaining <= remaining - TW'(1);
                if (elapsed_nxt == cur_dur) begin
                    counter_green  <= (phase_q == GREEN);
                    counter_yellow <= (phase_q == YELLOW);
                    counter_red    <= (phase_q == RED);
                end
            end
        end
    end

endmodule

// File: tb/tb_semaforo_timer.sv
// Bench for semaforo_timer: two instances (slow prescaler, raw clock) checked
// cycle by cycle against an age-since-capture reference model.
module tb_semaforo_timer;

    localparam int P_A = 4, G_A = 5, Y_A = 2, R_A = 3;
    localparam int P_B = 1, G_B = 1, Y_B = 2, R_B = 3;
    localparam int TW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          g_a, y_a, r_a, g_b, y_b, r_b;
    logic          cg_a, cy_a, cr_a, flt_a, cg_b, cy_b, cr_b, flt_b;
    logic [TW-1:0] rem_a, rem_b;

    semaforo_timer #(
        .PRESCALE(P_A), .GREEN_TICKS(G_A), .YELLOW_TICKS(Y_A), .RED_TICKS(R_A),
        .TW(TW), .PW(3)
    ) u_dut_a (
        .clk(clk), .rst(rst), .green(g_a), .yellow(y_a), .red(r_a),
        .counter_green(cg_a), .counter_yellow(cy_a), .counter_red(cr_a),
        .remaining(rem_a), .fault(flt_a)
    );

    semaforo_timer #(
        .PRESCALE(P_B), .GREEN_TICKS(G_B), .YELLOW_TICKS(Y_B), .RED_TICKS(R_B),
        .TW(TW), .PW(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .green(g_b), .yellow(y_b), .red(r_b),
        .counter_green(cg_b), .counter_yellow(cy_b), .counter_red(cr_b),
        .remaining(rem_b), .fault(flt_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int b_hold = 0;

    // Model phases: 0 none, 1 green, 2 yellow, 3 red, 4 illegal.
    int         m_ph[2]    = '{0, 0};
    int         m_age[2]   = '{0, 0};
    int         cap_cyc[2] = '{0, 0};
    logic [3:0] prev_fl[2] = '{4'b0, 4'b0};

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int dec(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int pre(input int i);
        return (i == 0) ? P_A : P_B;
    endfunction

    function automatic int dur(input int i, input int ph);
        case (ph)
            1:       return (i == 0) ? G_A : G_B;
            2:       return (i == 0) ? Y_A : Y_B;
            3:       return (i == 0) ? R_A : R_B;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] obs_fl(input int i);
        return (i == 0) ? {cg_a, cy_a, cr_a, flt_a} : {cg_b, cy_b, cr_b, flt_b};
    endfunction

    function automatic int obs_rem(input int i);
        return (i == 0) ? int'(rem_a) : int'(rem_b);
    endfunction

    task automatic model_update(input int i, input logic g, input logic y, input logic r);
        int d;
        if (rst) begin
            m_ph[i]  = 0;
            m_age[i] = 0;
        end else begin
            d = dec(g, y, r);
            if (d != m_ph[i]) begin
                m_ph[i]    = d;
                m_age[i]   = 0;
                cap_cyc[i] = cyc;
            end else begin
                m_age[i]++;
            end
        end
    endtask

    // Expected outputs: ticks elapsed = age / PRESCALE, saturated at the phase duration.
    task automatic check_inst(input int i);
        int         d, t, rem;
        logic [3:0] fl, o;
        fl  = '0;
        rem = 0;
        d   = dur(i, m_ph[i]);
        if (m_ph[i] == 4) begin
            fl[0] = 1'b1;
        end else if (d > 0) begin
            t = m_age[i] / pre(i);
            if (t > d) t = d;
            rem = d - t;
            if (t == d) begin
                case (m_ph[i])
                    1:       fl[3] = 1'b1;
                    2:       fl[2] = 1'b1;
                    default: fl[1] = 1'b1;
                endcase
            end
        end
        o = obs_fl(i);
        chk((i == 0) ? "flags_a" : "flags_b", int'(o), int'(fl));
        chk((i == 0) ? "remaining_a" : "remaining_b", obs_rem(i), rem);
        for (int k = 1; k < 4; k++) begin
            if (o[k] && !prev_fl[i][k])
                chk((i == 0) ? "rise_delay_a" : "rise_delay_b", cyc - cap_cyc[i], d * pre(i));
        end
        prev_fl[i] = o;
    endtask

    function automatic logic [2:0] pick(input int k);
        case (k)
            0, 1:    return 3'b100;
            2, 3:    return 3'b010;
            4, 5:    return 3'b001;
            6:       return 3'($urandom_range(0, 7));
            default: return 3'b110;
        endcase
    endfunction

    // Instance B: green/red toggle every 3 clocks first, then random holds.
    task automatic drive_b();
        if (cyc < 80) begin
            {g_b, y_b, r_b} = (((cyc / 3) % 2) == 1) ? 3'b001 : 3'b100;
        end else if (b_hold > 0) begin
            b_hold--;
        end else begin
            {g_b, y_b, r_b} = pick($urandom_range(0, 7));
            b_hold = $urandom_range(0, 5);
        end
    endtask

    task automatic step();
        drive_b();
        @(posedge clk);
        cyc++;
        model_update(0, g_a, y_a, r_a);
        model_update(1, g_b, y_b, r_b);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_a(input logic [2:0] v);
        {g_a, y_a, r_a} = v;
    endtask

    // Called just after a clock edge: the outputs must clear before any further edge.
    task automatic async_reset(input int n);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_ph[i]  = 0;
            m_age[i] = 0;
        end
        check_inst(0);
        check_inst(1);
        run(n);
        rst = 1'b0;
    endtask

    initial begin
        int last_green;
        int hold;
        rst = 1'b1;
        set_a(3'b000);
        {g_b, y_b, r_b} = 3'b000;
        run(3);
        rst = 1'b0;

        // Green held well past done, then yellow and red.
        set_a(3'b100); run(32);
        set_a(3'b010); run(12);
        set_a(3'b001); run(14);

        // Closed loop: the bench acts as the controller, reacting to each flag.
        last_green = -1;
        set_a(3'b100);
        for (int k = 0; k < 150; k++) begin
            step();
            if (m_ph[0] == 1 && m_age[0] == 0) begin
                if (last_green >= 0)
                    chk("loop_period", cyc - last_green,
                        (G_A * P_A + 1) + (Y_A * P_A + 1) + (R_A * P_A + 1));
                last_green = cyc;
            end
            if (g_a && cg_a)      set_a(3'b010);
            else if (y_a && cy_a) set_a(3'b001);
            else if (r_a && cr_a) set_a(3'b100);
        end

        // Illegal lights mid-green, then recovery.
        set_a(3'b100); run(8);
        set_a(3'b110); run(5);
        set_a(3'b100); run(24);

        // One-cycle glitch to yellow and back.
        set_a(3'b010); run(1);
        set_a(3'b100); run(22);

        // Reset in the middle of red.
        set_a(3'b001); run(6);
        async_reset(1);
        run(15);

        // Random light sequences with occasional faults and a reset.
        hold = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold == 0) begin
                set_a(pick($urandom_range(0, 7)));
                hold = $urandom_range(1, 30);
            end
            hold--;
            if (k == 200) async_reset(2);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
